// File: rtl/modular_square_pkg.sv
// Shared types and default depths for the modular-squaring sequence controller.
package modular_square_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

  localparam int DEF_MOD_LEN    = 1024;
  localparam int DEF_IN_STAGES  = 3;
  localparam int DEF_OUT_STAGES = 3;
  localparam int DEF_CNT_W      = 32;

  // Cycles the core is held in reset after a stop: long enough for the reset
  // to cross the input pipe and for every in-flight result to leave the output pipe.
  function automatic int drain_cycles(input int in_st, input int out_st);
    return in_st + out_st + 2;
  endfunction

endpackage

// File: rtl/modsq_delay_pipe.sv
// Generic register delay line used to cross SLR boundaries between controller and core.
module modsq_delay_pipe #(
  parameter int             WIDTH     = 1,
  parameter int             DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit             HAS_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  if (HAS_RESET) begin : g_rst
    // Control bits: every stage starts at RESET_VAL so the far side sees a safe value.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end
  end else begin : g_norst
    logic w_unused_rst;
    assign w_unused_rst = reset_n;
    // Wide data bits: no reset, they are qualified by the control pipes.
    always_ff @(posedge clk) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/modular_square_seq_ctrl.sv
// Runs T back-to-back modular squarings on an external core through
// configurable in/out delay pipes, streaming every intermediate square.
//
// Handshake: start is a request sampled only in IDLE (no ready; it is simply
// ignored while busy). valid, done and aborted are single-cycle pulses with no
// back-pressure; sq_out/iter_idx are stable whenever valid or done is high and
// hold until the next update. core_valid is a strobe qualified by the mask.
module modular_square_seq_ctrl
  import modular_square_pkg::*;
#(
  parameter int MOD_LEN    = DEF_MOD_LEN,
  parameter int IN_STAGES  = DEF_IN_STAGES,
  parameter int OUT_STAGES = DEF_OUT_STAGES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DRAIN_CYC  = drain_cycles(IN_STAGES, OUT_STAGES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   iter_count,
  input  logic [MOD_LEN-1:0] sq_in,
  input  logic               abort,
  output logic               busy,
  output logic               valid,
  output logic [CNT_W-1:0]   iter_idx,
  output logic [MOD_LEN-1:0] sq_out,
  output logic               done,
  output logic               aborted,
  output logic               core_reset,
  output logic               core_start,
  output logic [MOD_LEN-1:0] core_sq_in,
  input  logic               core_valid,
  input  logic [MOD_LEN-1:0] core_sq,
  output logic [1:0]         o_dbg_state
);

  localparam int DCW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  seq_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_t;
  logic [MOD_LEN-1:0] r_seed;
  logic [DRAIN_CYC-1:0] r_mask;
  logic [DCW-1:0]     r_drain_cnt;
  logic               r_pend_done;
  logic               r_busy, r_valid, r_done, r_aborted;
  logic [CNT_W-1:0]   r_iter_idx;
  logic [MOD_LEN-1:0] r_sq_out;

  logic               w_pvalid;
  logic [MOD_LEN-1:0] w_psq;
  logic               w_accept, w_last, w_start_ok, w_start_zero;
  logic               w_drain_enter, w_drain_exit;
  logic [CNT_W-1:0]   w_idx_inc;
  logic               w_core_start_d, w_core_reset_d;

  assign w_start_ok    = (r_state == IDLE) && start && (iter_count != '0);
  assign w_start_zero  = (r_state == IDLE) && start && (iter_count == '0);
  assign w_accept      = (r_state == RUN) && w_pvalid && !r_mask[0];
  assign w_idx_inc     = r_iter_idx + CNT_W'(1);
  assign w_last        = w_accept && (w_idx_inc == r_t);
  assign w_drain_enter = ((r_state == LOAD) && abort) ||
                         ((r_state == RUN) && (w_last || abort));
  assign w_drain_exit  = (r_state == DRAIN) && (r_drain_cnt == DCW'(DRAIN_CYC));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; the final result beats a simultaneous abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = abort ? DRAIN : RUN;
      RUN:     if (w_last || abort) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_exit) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Core control driven into the input pipe: reset everywhere except LOAD/RUN.
  always_comb begin
    w_core_start_d = 1'b0;
    w_core_reset_d = 1'b1;
    case (r_state)
      LOAD:    begin w_core_start_d = 1'b1; w_core_reset_d = 1'b0; end
      RUN:     w_core_reset_d = 1'b0;
      default: w_core_reset_d = 1'b1;
    endcase
  end

  // Run bookkeeping and host-facing result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_t         <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_iter_idx  <= '0;
      r_sq_out    <= '0;
      r_pend_done <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_valid   <= w_accept;
      r_done    <= w_start_zero || (w_drain_exit && r_pend_done);
      r_aborted <= w_drain_exit && !r_pend_done;
      if (w_start_ok) begin
        r_t        <= iter_count;
        r_iter_idx <= '0;
        r_busy     <= 1'b1;
      end
      if (w_start_zero) begin
        r_sq_out   <= sq_in;
        r_iter_idx <= '0;
      end
      if (w_accept) begin
        r_sq_out   <= w_psq;
        r_iter_idx <= w_idx_inc;
      end
      if (w_drain_enter) r_pend_done <= w_last;
      if (w_drain_exit)  r_busy      <= 1'b0;
      if (w_drain_enter)             r_drain_cnt <= '0;
      else if (r_state == DRAIN)     r_drain_cnt <= r_drain_cnt + DCW'(1);
    end
  end

  // Valid mask: refilled on reset and on each stop so stale core results die out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_mask <= '1;
    else if (w_drain_enter) r_mask <= '1;
    else                    r_mask <= r_mask >> 1;
  end

  // Seed is plain data, captured with an accepted start.
  always_ff @(posedge clk) begin
    if (w_start_ok) r_seed <= sq_in;
  end

  modsq_delay_pipe #(.WIDTH(1), .DEPTH(IN_STAGES), .RESET_VAL(1'b0), .HAS_RESET(1'b1))
    u_start_pipe (.clk(clk), .reset_n(reset_n), .i_d(w_core_start_d), .o_q(core_start));
  modsq_delay_pipe #(.WIDTH(1), .DEPTH(IN_STAGES), .RESET_VAL(1'b1), .HAS_RESET(1'b1))
    u_reset_pipe (.clk(clk), .reset_n(reset_n), .i_d(w_core_reset_d), .o_q(core_reset));
  modsq_delay_pipe #(.WIDTH(MOD_LEN), .DEPTH(IN_STAGES), .HAS_RESET(1'b0))
    u_seed_pipe (.clk(clk), .reset_n(reset_n), .i_d(r_seed), .o_q(core_sq_in));
  modsq_delay_pipe #(.WIDTH(1), .DEPTH(OUT_STAGES), .RESET_VAL(1'b0), .HAS_RESET(1'b1))
    u_valid_pipe (.clk(clk), .reset_n(reset_n), .i_d(core_valid), .o_q(w_pvalid));
  modsq_delay_pipe #(.WIDTH(MOD_LEN), .DEPTH(OUT_STAGES), .HAS_RESET(1'b0))
    u_sq_pipe (.clk(clk), .reset_n(reset_n), .i_d(core_sq), .o_q(w_psq));

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign iter_idx    = r_iter_idx;
  assign sq_out      = r_sq_out;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign o_dbg_state = r_state;

endmodule
